// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds predicted branches from fetch and drives predictor updates and
// mispredict redirects as execute resolves them in order. Optional counters: BRQ_STATS_EN.
module branch_resolve_queue #(
   parameter int unsigned K     = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PC_W  = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     alloc_valid_i,
   input  logic [K-1:0]             alloc_index_i,
   input  logic                     alloc_pred_i,
   input  logic [PC_W-1:0]          alloc_fall_pc_i,
   input  logic [PC_W-1:0]          alloc_targ_pc_i,
   output logic                     alloc_ready_o,
   input  logic                     resolve_valid_i,
   input  logic                     resolve_taken_i,
   output logic                     update_o,
   output logic [K-1:0]             up_index_o,
   output logic                     result_o,
   output logic                     mispredict_o,
   output logic [PC_W-1:0]          redirect_pc_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     resolve_err_o,
   output logic [15:0]              stat_resolved_o,
   output logic [15:0]              stat_mispred_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [K-1:0]    idx_q  [DEPTH];
   logic            pred_q [DEPTH];
   logic [PC_W-1:0] fall_q [DEPTH];
   logic [PC_W-1:0] targ_q [DEPTH];

   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            update_q, mispredict_q, result_q, err_q;
   logic [K-1:0]    up_index_q;
   logic [PC_W-1:0] redirect_q;

   logic alloc_fire, res_fire, mis;

   assign alloc_ready_o = (count_q != CW'(DEPTH));
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;
   assign res_fire      = resolve_valid_i && (count_q != '0);
   assign mis           = resolve_taken_i != pred_q[head_q];

   // Entry storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk_i) begin
      if (alloc_fire) begin
         idx_q[tail_q]  <= alloc_index_i;
         pred_q[tail_q] <= alloc_pred_i;
         fall_q[tail_q] <= alloc_fall_pc_i;
         targ_q[tail_q] <= alloc_targ_pc_i;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (res_fire && mis) begin
         // Everything behind a mispredicted head is wrong-path, including a same-cycle alloc.
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc_fire) tail_d = tail_q + PW'(1);
         if (res_fire)   head_d = head_q + PW'(1);
         count_d = count_q + CW'(alloc_fire) - CW'(res_fire);
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         update_q     <= 1'b0;
         mispredict_q <= 1'b0;
         result_q     <= 1'b0;
         up_index_q   <= '0;
         redirect_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         update_q     <= res_fire;
         mispredict_q <= res_fire && mis;
         if (res_fire) begin
            up_index_q <= idx_q[head_q];
            result_q   <= resolve_taken_i;
            redirect_q <= resolve_taken_i ? targ_q[head_q] : fall_q[head_q];
         end
         if (resolve_valid_i && (count_q == '0)) err_q <= 1'b1;
      end
   end

`ifdef BRQ_STATS_EN
   logic [15:0] stat_res_q, stat_mis_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else if (res_fire) begin
         if (stat_res_q != 16'hFFFF) stat_res_q <= stat_res_q + 16'd1;
         if (mis && (stat_mis_q != 16'hFFFF)) stat_mis_q <= stat_mis_q + 16'd1;
      end
   end

   assign stat_resolved_o = stat_res_q;
   assign stat_mispred_o  = stat_mis_q;
`else
   assign stat_resolved_o = '0;
   assign stat_mispred_o  = '0;
`endif

   assign update_o      = update_q;
   assign up_index_o    = up_index_q;
   assign result_o      = result_q;
   assign mispredict_o  = mispredict_q;
   assign redirect_pc_o = redirect_q;
   assign count_o       = count_q;
   assign resolve_err_o = err_q;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
Update-side companion to the 2-bit saturating-counter branch predictor.
- Fetch pushes each predicted branch: table index, predicted direction, fall-through and taken PCs.
- Execute resolves branches in program order.
- On each resolve the block drives the predictor's update/up_index/result interface and flags mispredicts with a redirect PC.
- Sits between the fetch and execute stages of the LC-3b pipeline.

Parameters:
K, 4, predictor index width; matches the predictor's k
DEPTH, 4, queue entries; power of two, >=2
PC_W, 16, PC width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
alloc_valid  in  1  fetch pushes a predicted branch
alloc_index  in  K  predictor index used at prediction time
alloc_pred  in  1  predicted direction (1 = taken)
alloc_fall_pc  in  PC_W  fall-through PC
alloc_targ_pc  in  PC_W  taken-target PC
alloc_ready  out  1  queue not full
resolve_valid  in  1  oldest outstanding branch resolved this cycle
resolve_taken  in  1  actual direction
update  out  1  predictor update strobe
up_index  out  K  predictor index to update
result  out  1  actual direction to predictor
mispredict  out  1  one-cycle flush pulse
redirect_pc  out  PC_W  correct PC, valid while mispredict=1
count  out  $clog2(DEPTH)+1  occupancy
resolve_err  out  1  sticky: resolve seen while empty
stat_resolved  out  16  resolved-branch count (optional feature)
stat_mispred  out  16  mispredict count (optional feature)

Behaviour:
- Reset (async on reset_n low):
  - Head/tail pointers and count go to 0.
  - update, mispredict, resolve_err and stat_* go to 0.
  - up_index, result and redirect_pc go to 0.
  - alloc_ready goes to 1.
- alloc_ready is combinational: count != DEPTH.
- Storage is circular; head and tail wrap modulo DEPTH.
- Allocate:
  - When alloc_valid && alloc_ready, the entry is written at tail at the clock edge, then tail++ and count++.
  - alloc_valid while full: ignored, no state change.
- Resolve:
  - When resolve_valid && count != 0, the head entry is read combinationally and the outputs are registered. They are visible 1 cycle after the resolve edge.
  - update=1, up_index=entry.index, result=resolve_taken.
  - mispredict = (resolve_taken != entry.pred).
  - redirect_pc = resolve_taken ? entry.targ_pc : entry.fall_pc.
  - update and mispredict are single-cycle pulses. up_index, result and redirect_pc hold their last value otherwise.
- Correct prediction: head++, count--.
- Mispredict:
  - All entries are younger than head, so they are wrong-path.
  - Queue is cleared: head=tail=0, count=0.
  - A same-cycle alloc is dropped.
- Resolve and alloc in the same cycle with correct prediction: both take effect; count is unchanged.
  - Legal even when full: a resolve frees head, but alloc_ready still reflects the pre-edge count, so alloc while full is dropped.
- resolve_valid while empty: ignored, no update pulse; resolve_err sets and stays set until reset.
- Reset mid-operation: all entries are discarded and any pending pulse is killed immediately.

Optional Feature:
BRQ_STATS_EN.
- Defined:
  - stat_resolved increments on every accepted resolve.
  - stat_mispred increments on every mispredict.
  - Both are 16-bit, saturate at 16'hFFFF, and are registered alongside update.
- Undefined: no counter logic; both ports are tied to 0.

Test Plan:
- Reset, then 4 allocs (idx 1,2,3,4; pred 1,0,1,0) with no resolve -> count=4, alloc_ready=0; a 5th alloc (idx 5) is dropped and count stays 4.
- Resolve taken=1 on head idx 1 (pred 1) -> next cycle update=1, up_index=1, result=1, mispredict=0; count=3.
- Alloc idx 7 (pred 0, fall 16'h3002, targ 16'h3040), resolve it taken=1 -> mispredict=1, redirect_pc=16'h3040; count=0 afterwards, including after a same-cycle alloc.
- Queue holding 2 entries, simultaneous alloc plus correct resolve -> count stays 2; the next resolve presents the second-oldest index.
- Resolve with the queue empty -> no update pulse; resolve_err=1 and stays 1 across 10 cycles; reset_n low clears it.
- With BRQ_STATS_EN defined: 3 resolves with 1 mispredict -> stat_resolved=3, stat_mispred=1; reset_n pulsed low mid-sequence -> both counters and count go to 0 asynchronously.
